// File: rtl/othello_task_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : othello_task_feeder
//  Purpose  : Feeds host-supplied Othello boards to a single endgame solver
//             and collects the solver's results into a host-side FIFO.
//             When no task is queued the solver is handed a DUMMY board
//             (full board, terminates at once); results for DUMMY boards
//             are discarded, and every DUMMY issue is counted as a bubble.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    iCLOCK, inRESET                 clock (rising edge), async active-low reset
//    iTaskValid/oTaskReady           host task push handshake
//    iTaskPlayer/iTaskOpponent       task board (64 + 64 bits)
//    oEnable, oPlayer, oOpponent     solver enable and presented board
//    iTake                           solver captured the presented board
//    iSolved, iSolvedPlayer,
//    iSolvedOpponent, iSolvedRes     solver result pulse and payload
//    oResValid/iResReady             host result pop handshake (FWFT)
//    oResPlayer, oResOpponent, oRes  result FIFO head
//    oOverflow                       sticky: a result was dropped
//    oBubbles                        saturating count of DUMMY boards taken
// ============================================================================
module othello_task_feeder #(
    parameter int TASK_DEPTH = 4,
    parameter int RES_DEPTH  = 8
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iTaskValid,
    output logic               oTaskReady,
    input  logic [63:0]        iTaskPlayer,
    input  logic [63:0]        iTaskOpponent,
    output logic               oEnable,
    output logic [63:0]        oPlayer,
    output logic [63:0]        oOpponent,
    input  logic               iTake,
    input  logic               iSolved,
    input  logic [63:0]        iSolvedPlayer,
    input  logic [63:0]        iSolvedOpponent,
    input  logic signed [7:0]  iSolvedRes,
    output logic               oResValid,
    input  logic               iResReady,
    output logic [63:0]        oResPlayer,
    output logic [63:0]        oResOpponent,
    output logic signed [7:0]  oRes,
    output logic               oOverflow,
    output logic [15:0]        oBubbles
);

    localparam int TAW = $clog2(TASK_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);

    localparam logic [63:0]  DUMMY_PLAYER   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]  DUMMY_OPPONENT = 64'h0;
    localparam logic [TAW:0] TASK_PTR_ONE   = {{TAW{1'b0}}, 1'b1};
    localparam logic [RAW:0] RES_PTR_ONE    = {{RAW{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Control state machine
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Task FIFO (pointers carry one extra bit to tell full from empty)
    // ------------------------------------------------------------------
    logic [127:0] task_mem [TASK_DEPTH];
    logic [TAW:0] task_wptr;
    logic [TAW:0] task_rptr;
    logic         task_empty;
    logic         task_full;
    logic         task_push;
    logic         task_pop;
    logic         take_run;
    logic         bubble;
    logic [127:0] task_head;

    assign task_empty = (task_wptr == task_rptr);
    assign task_full  = (task_wptr[TAW] != task_rptr[TAW]) &&
                        (task_wptr[TAW-1:0] == task_rptr[TAW-1:0]);
    assign task_head  = task_mem[task_rptr[TAW-1:0]];

    assign take_run   = iTake && (state == RUN);
    assign task_push  = iTaskValid && !task_full;
    // A take on an empty FIFO consumes the DUMMY board; a task pushed in
    // the same cycle is not yet visible and therefore stays as the head.
    assign task_pop   = take_run && !task_empty;
    assign bubble     = take_run && task_empty;

    assign oTaskReady = !task_full;
    assign oPlayer    = task_empty ? DUMMY_PLAYER   : task_head[127:64];
    assign oOpponent  = task_empty ? DUMMY_OPPONENT : task_head[63:0];
    assign oEnable    = (state == RUN);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!task_empty) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (task_push) begin
            task_mem[task_wptr[TAW-1:0]] <= {iTaskPlayer, iTaskOpponent};
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            task_wptr <= '0;
            task_rptr <= '0;
            oBubbles  <= 16'h0;
        end else begin
            if (task_push) task_wptr <= task_wptr + TASK_PTR_ONE;
            if (task_pop)  task_rptr <= task_rptr + TASK_PTR_ONE;
            if (bubble && (oBubbles != 16'hFFFF)) begin
                oBubbles <= oBubbles + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [135:0] res_mem [RES_DEPTH];
    logic [RAW:0] res_wptr;
    logic [RAW:0] res_rptr;
    logic         res_empty;
    logic         res_full;
    logic         res_pop;
    logic         res_cand;
    logic         res_push;
    logic         res_drop;
    logic         res_is_dummy;
    logic [135:0] res_head;

    assign res_empty = (res_wptr == res_rptr);
    assign res_full  = (res_wptr[RAW] != res_rptr[RAW]) &&
                       (res_wptr[RAW-1:0] == res_rptr[RAW-1:0]);
    assign res_head  = res_mem[res_rptr[RAW-1:0]];

    // DUMMY results may arrive in either colour order, since the solver
    // can report the board from the side to move after a pass.
    assign res_is_dummy =
        ({iSolvedPlayer, iSolvedOpponent} == {DUMMY_PLAYER, DUMMY_OPPONENT}) ||
        ({iSolvedPlayer, iSolvedOpponent} == {DUMMY_OPPONENT, DUMMY_PLAYER});

    assign res_pop  = !res_empty && iResReady;
    assign res_cand = iSolved && !res_is_dummy;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign res_push = res_cand && (!res_full || res_pop);
    assign res_drop = res_cand && res_full && !res_pop;

    assign oResValid    = !res_empty;
    assign oResPlayer   = res_empty ? 64'h0 : res_head[135:72];
    assign oResOpponent = res_empty ? 64'h0 : res_head[71:8];
    assign oRes         = res_empty ? 8'sh0 : res_head[7:0];

    always_ff @(posedge iCLOCK) begin
        if (res_push) begin
            res_mem[res_wptr[RAW-1:0]] <= {iSolvedPlayer, iSolvedOpponent, iSolvedRes};
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            res_wptr  <= '0;
            res_rptr  <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (res_push) res_wptr <= res_wptr + RES_PTR_ONE;
            if (res_pop)  res_rptr <= res_rptr + RES_PTR_ONE;
            if (res_drop) oOverflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_othello_task_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_othello_task_feeder
//  Purpose  : Self-checking bench for othello_task_feeder: directed scenarios
//             plus a randomized run against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_othello_task_feeder;

    localparam int TASK_DEPTH = 4;
    localparam int RES_DEPTH  = 8;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic              iCLOCK = 1'b0;
    logic              inRESET = 1'b0;
    logic              iTaskValid = 1'b0;
    logic              oTaskReady;
    logic [63:0]       iTaskPlayer = '0;
    logic [63:0]       iTaskOpponent = '0;
    logic              oEnable;
    logic [63:0]       oPlayer;
    logic [63:0]       oOpponent;
    logic              iTake = 1'b0;
    logic              iSolved = 1'b0;
    logic [63:0]       iSolvedPlayer = '0;
    logic [63:0]       iSolvedOpponent = '0;
    logic signed [7:0] iSolvedRes = '0;
    logic              oResValid;
    logic              iResReady = 1'b0;
    logic [63:0]       oResPlayer;
    logic [63:0]       oResOpponent;
    logic signed [7:0] oRes;
    logic              oOverflow;
    logic [15:0]       oBubbles;

    int n_cmp = 0;
    int n_bad = 0;

    othello_task_feeder #(
        .TASK_DEPTH (TASK_DEPTH),
        .RES_DEPTH  (RES_DEPTH)
    ) dut (
        .iCLOCK          (iCLOCK),
        .inRESET         (inRESET),
        .iTaskValid      (iTaskValid),
        .oTaskReady      (oTaskReady),
        .iTaskPlayer     (iTaskPlayer),
        .iTaskOpponent   (iTaskOpponent),
        .oEnable         (oEnable),
        .oPlayer         (oPlayer),
        .oOpponent       (oOpponent),
        .iTake           (iTake),
        .iSolved         (iSolved),
        .iSolvedPlayer   (iSolvedPlayer),
        .iSolvedOpponent (iSolvedOpponent),
        .iSolvedRes      (iSolvedRes),
        .oResValid       (oResValid),
        .iResReady       (iResReady),
        .oResPlayer      (oResPlayer),
        .oResOpponent    (oResOpponent),
        .oRes            (oRes),
        .oOverflow       (oOverflow),
        .oBubbles        (oBubbles)
    );

    always #5 iCLOCK = ~iCLOCK;

    // Advance one rising edge, land 1 time unit after it.
    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic idle_inputs();
        iTaskValid = 1'b0; iTake = 1'b0; iSolved = 1'b0; iResReady = 1'b0;
        iTaskPlayer = '0; iTaskOpponent = '0;
        iSolvedPlayer = '0; iSolvedOpponent = '0; iSolvedRes = '0;
    endtask

    // Reset asserted and released between clock edges.
    task automatic do_reset();
        idle_inputs();
        tick();
        inRESET = 1'b0;
        #2;
        inRESET = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        tick();
        inRESET = 1'b0;
        #2;
        n_cmp++;
        if ({oEnable, oTaskReady, oResValid, oOverflow} !== 4'b0100) begin
            n_bad++;
            $display("FAIL reset_flags: got en/rdy/rv/ovf=%b expected 0100",
                     {oEnable, oTaskReady, oResValid, oOverflow});
        end
        n_cmp++;
        if (oBubbles !== 16'h0) begin
            n_bad++; $display("FAIL reset_bubbles: got %h expected 0000", oBubbles);
        end
        n_cmp++;
        if ({oPlayer, oOpponent} !== {ONES, 64'h0}) begin
            n_bad++; $display("FAIL reset_board: got %h/%h expected dummy", oPlayer, oOpponent);
        end
        n_cmp++;
        if ({oResPlayer, oResOpponent, oRes} !== 136'h0) begin
            n_bad++; $display("FAIL reset_result: got %h/%h/%h expected 0", oResPlayer, oResOpponent, oRes);
        end
        inRESET = 1'b1;
        tick();
    endtask

    task automatic test_push_a();
        do_reset();
        iTaskValid = 1'b1;
        iTaskPlayer = 64'h0000_0008_1000_0000;
        iTaskOpponent = 64'h0000_0010_0800_0000;
        tick();
        iTaskValid = 1'b0;
        n_cmp++;
        if ({oPlayer, oOpponent} !== {64'h0000_0008_1000_0000, 64'h0000_0010_0800_0000}) begin
            n_bad++; $display("FAIL push_a_board: got %h/%h expected task A", oPlayer, oOpponent);
        end
        n_cmp++;
        if (oEnable !== 1'b0) begin
            n_bad++; $display("FAIL push_a_enable_early: got %b expected 0", oEnable);
        end
        tick();
        n_cmp++;
        if (oEnable !== 1'b1) begin
            n_bad++; $display("FAIL push_a_enable: got %b expected 1", oEnable);
        end
    endtask

    task automatic test_task_full();
        do_reset();
        for (int i = 0; i < TASK_DEPTH; i++) begin
            iTaskValid = 1'b1;
            iTaskPlayer = 64'h1000 + 64'(i);
            iTaskOpponent = 64'h2000 + 64'(i);
            tick();
        end
        iTaskValid = 1'b0;
        n_cmp++;
        if (oTaskReady !== 1'b0) begin
            n_bad++; $display("FAIL full_ready: got %b expected 0", oTaskReady);
        end
        n_cmp++;
        if (oPlayer !== 64'h1000) begin
            n_bad++; $display("FAIL full_head: got %h expected 1000", oPlayer);
        end
        iTake = 1'b1;
        tick();
        iTake = 1'b0;
        n_cmp++;
        if (oTaskReady !== 1'b1) begin
            n_bad++; $display("FAIL full_ready_after_take: got %b expected 1", oTaskReady);
        end
        n_cmp++;
        if ({oPlayer, oOpponent} !== {64'h1001, 64'h2001}) begin
            n_bad++; $display("FAIL full_second_task: got %h/%h expected 1001/2001", oPlayer, oOpponent);
        end
    endtask

    task automatic test_bubbles_and_dummy();
        do_reset();
        // iTake while still IDLE must be ignored.
        iTake = 1'b1;
        tick();
        iTake = 1'b0;
        n_cmp++;
        if (oBubbles !== 16'h0) begin
            n_bad++; $display("FAIL idle_take_ignored: got %h expected 0000", oBubbles);
        end
        iTaskValid = 1'b1; iTaskPlayer = 64'hAB; iTaskOpponent = 64'hCD;
        tick();
        iTaskValid = 1'b0;
        tick();
        iTake = 1'b1;
        tick();                       // pops the one task
        tick(); tick(); tick();       // three DUMMY takes
        iTake = 1'b0;
        n_cmp++;
        if (oBubbles !== 16'd3) begin
            n_bad++; $display("FAIL bubbles_three: got %0d expected 3", oBubbles);
        end
        n_cmp++;
        if ({oPlayer, oOpponent} !== {ONES, 64'h0}) begin
            n_bad++; $display("FAIL bubbles_dummy_board: got %h/%h expected dummy", oPlayer, oOpponent);
        end
        // Take and push coinciding on an empty FIFO.
        iTake = 1'b1; iTaskValid = 1'b1; iTaskPlayer = 64'h55; iTaskOpponent = 64'h66;
        tick();
        iTake = 1'b0; iTaskValid = 1'b0;
        n_cmp++;
        if ({oBubbles, oPlayer, oOpponent} !== {16'd4, 64'h55, 64'h66}) begin
            n_bad++; $display("FAIL take_push_empty: got %0d %h/%h expected 4 55/66", oBubbles, oPlayer, oOpponent);
        end
        iSolved = 1'b1; iSolvedPlayer = ONES; iSolvedOpponent = 64'h0; iSolvedRes = 8'sd5;
        tick();
        iSolvedPlayer = 64'h0; iSolvedOpponent = ONES;
        tick();
        iSolved = 1'b0;
        tick();
        n_cmp++;
        if (oResValid !== 1'b0) begin
            n_bad++; $display("FAIL dummy_result_dropped: got %b expected 0", oResValid);
        end
    endtask

    task automatic test_overflow();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int i = 0; i < RES_DEPTH + 1; i++) begin
                iSolved = 1'b1;
                iSolvedPlayer = 64'h100 + 64'(i);
                iSolvedOpponent = 64'(i);
                iSolvedRes = 8'(i);
                iResReady = (pass == 1) && (i == RES_DEPTH);
                tick();
            end
            iSolved = 1'b0; iResReady = 1'b0;
            n_cmp++;
            if (oOverflow !== (pass == 0)) begin
                n_bad++; $display("FAIL overflow_flag_pass%0d: got %b expected %b", pass, oOverflow, pass == 0);
            end
            // Drain and check arrival order.  Pass 1 already popped result 0.
            for (int k = 0; k < RES_DEPTH; k++) begin
                int idx;
                idx = k + pass;
                iResReady = 1'b1;
                n_cmp++;
                if ({oResValid, oResPlayer, oResOpponent, oRes} !==
                    {1'b1, 64'h100 + 64'(idx), 64'(idx), 8'(idx)}) begin
                    n_bad++;
                    $display("FAIL drain_pass%0d_%0d: got v=%b %h/%h/%h expected result %0d",
                             pass, k, oResValid, oResPlayer, oResOpponent, oRes, idx);
                end
                tick();
            end
            iResReady = 1'b0;
            n_cmp++;
            if (oResValid !== 1'b0) begin
                n_bad++; $display("FAIL drain_empty_pass%0d: got %b expected 0", pass, oResValid);
            end
        end
    endtask

    task automatic test_result_and_async_reset();
        do_reset();
        iSolved = 1'b1; iSolvedPlayer = 64'h1234_5678_9ABC_DEF0;
        iSolvedOpponent = 64'h0F0F_0000_1111_2222; iSolvedRes = -8'sd12;
        tick();
        iSolved = 1'b0;
        n_cmp++;
        if ({oResValid, oRes} !== {1'b1, 8'hF4}) begin
            n_bad++; $display("FAIL res_echo_value: got v=%b res=%h expected 1 f4", oResValid, oRes);
        end
        n_cmp++;
        if ({oResPlayer, oResOpponent} !== {64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_1111_2222}) begin
            n_bad++; $display("FAIL res_echo_payload: got %h/%h", oResPlayer, oResOpponent);
        end
        iTaskValid = 1'b1; iTaskPlayer = 64'h77; iTaskOpponent = 64'h88;
        tick(); tick();
        iTaskValid = 1'b0; iTake = 1'b1;
        tick(); tick(); tick();
        iTake = 1'b0;
        iSolved = 1'b1; iSolvedRes = 8'sd3;
        tick();
        iSolved = 1'b0;
        // Mid-burst reset, away from any clock edge.
        #2;
        inRESET = 1'b0;
        #1;
        n_cmp++;
        if ({oEnable, oTaskReady, oResValid, oOverflow, oBubbles} !== {4'b0100, 16'h0}) begin
            n_bad++; $display("FAIL async_reset_flags: got %b %h expected 0100 0000",
                              {oEnable, oTaskReady, oResValid, oOverflow}, oBubbles);
        end
        n_cmp++;
        if ({oPlayer, oOpponent, oResPlayer, oResOpponent, oRes} !== {ONES, 64'h0, 136'h0}) begin
            n_bad++; $display("FAIL async_reset_data: got %h/%h res %h", oPlayer, oOpponent, oRes);
        end
        #1;
        inRESET = 1'b1;
        tick();
        n_cmp++;
        if ({oEnable, oResValid, oPlayer} !== {2'b00, ONES}) begin
            n_bad++; $display("FAIL after_reset_fresh: got en=%b rv=%b player=%h", oEnable, oResValid, oPlayer);
        end
    endtask

    task automatic test_random();
        logic [127:0] tq[$];
        logic [135:0] rq[$];
        bit           en_m;
        int           bub_m;
        bit           ovf_m;
        logic [127:0] exp_task;
        logic [135:0] exp_res;
        do_reset();
        en_m = 0; bub_m = 0; ovf_m = 0;
        for (int c = 0; c < 600; c++) begin
            int  tsz;
            int  rsz;
            int  sel;
            bit  dummy_res;
            iTaskValid    = ($urandom_range(0, 1) == 1);
            iTaskPlayer   = {$urandom, $urandom};
            iTaskOpponent = {$urandom, $urandom};
            iTake         = ($urandom_range(0, 9) < 4);
            iResReady     = ($urandom_range(0, 9) < 3);
            iSolved       = ($urandom_range(0, 9) < 4);
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                iSolvedPlayer = ONES; iSolvedOpponent = 64'h0;
            end else if (sel == 1) begin
                iSolvedPlayer = 64'h0; iSolvedOpponent = ONES;
            end else begin
                iSolvedPlayer = {$urandom, $urandom}; iSolvedOpponent = {$urandom, $urandom};
            end
            iSolvedRes = 8'($urandom);

            // Reference model: state is taken just before the edge.
            tsz = tq.size();
            rsz = rq.size();
            dummy_res = (sel < 2);
            if (en_m && iTake) begin
                if (tsz > 0) void'(tq.pop_front());
                else if (bub_m < 65535) bub_m++;
            end
            if (iTaskValid && tsz < TASK_DEPTH) tq.push_back({iTaskPlayer, iTaskOpponent});
            if (rsz > 0 && iResReady) void'(rq.pop_front());
            if (iSolved && !dummy_res) begin
                if (rsz < RES_DEPTH || (rsz > 0 && iResReady))
                    rq.push_back({iSolvedPlayer, iSolvedOpponent, iSolvedRes});
                else
                    ovf_m = 1;
            end
            if (tsz > 0) en_m = 1;

            tick();

            exp_task = (tq.size() > 0) ? tq[0] : {ONES, 64'h0};
            exp_res  = (rq.size() > 0) ? rq[0] : 136'h0;
            n_cmp++;
            if ({oEnable, oTaskReady, oResValid, oOverflow} !==
                {en_m, tq.size() < TASK_DEPTH, rq.size() > 0, ovf_m}) begin
                n_bad++;
                $display("FAIL rand_flags cyc %0d: got %b expected %b", c,
                         {oEnable, oTaskReady, oResValid, oOverflow},
                         {en_m, tq.size() < TASK_DEPTH, rq.size() > 0, ovf_m});
            end
            n_cmp++;
            if ({oPlayer, oOpponent} !== exp_task) begin
                n_bad++; $display("FAIL rand_board cyc %0d: got %h expected %h", c, {oPlayer, oOpponent}, exp_task);
            end
            n_cmp++;
            if ({oResPlayer, oResOpponent, oRes} !== exp_res) begin
                n_bad++; $display("FAIL rand_result cyc %0d: got %h expected %h", c,
                                  {oResPlayer, oResOpponent, oRes}, exp_res);
            end
            n_cmp++;
            if (oBubbles !== 16'(bub_m)) begin
                n_bad++; $display("FAIL rand_bubbles cyc %0d: got %0d expected %0d", c, oBubbles, bub_m);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_push_a();
        test_task_full();
        test_bubbles_and_dummy();
        test_overflow();
        test_result_and_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/othello_task_feeder.md
OTHELLO_TASK_FEEDER -- requirements
Module: othello_task_feeder

Interface
REQ-001 The block SHALL have parameter TASK_DEPTH, default 4: task FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter RES_DEPTH, default 8: result FIFO entries (power of two, >=2).
REQ-003 The block SHALL have port iCLOCK, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port inRESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports iTaskValid (input, 1), oTaskReady (output, 1), iTaskPlayer (input, 64) and iTaskOpponent (input, 64): host task push.
REQ-006 The block SHALL have ports oEnable (output, 1), oPlayer (output, 64) and oOpponent (output, 64): drive the solver's enable, iPlayer and iOpponent.
REQ-007 The block SHALL have port iTake, input, 1 bit: the solver captured the presented board this cycle (solve restart or start slot).
REQ-008 The block SHALL have ports iSolved (input, 1), iSolvedPlayer (input, 64), iSolvedOpponent (input, 64) and iSolvedRes (input, 8, signed): the solver result pulse and its payload.
REQ-009 The block SHALL have ports oResValid (output, 1), iResReady (input, 1), oResPlayer (output, 64), oResOpponent (output, 64) and oRes (output, 8, signed): host result pop.
REQ-010 The block SHALL have ports oOverflow (output, 1, sticky result-drop flag) and oBubbles (output, 16, dummy-issue count).

Function
REQ-011 The DUMMY board SHALL be player = 64'hFFFF_FFFF_FFFF_FFFF, opponent = 0 (full board, terminates immediately).
REQ-012 The state machine SHALL have states IDLE (oEnable=0) and RUN (oEnable=1), with oEnable registered.
REQ-013 IDLE SHALL move to RUN on the edge where the task FIFO is non-empty; RUN SHALL have no exit except reset.
REQ-014 oTaskReady SHALL be 1 iff the task FIFO is not full, independent of same-cycle pop; a push occurs when iTaskValid & oTaskReady.
REQ-015 oPlayer/oOpponent SHALL combinationally show the task FIFO head when non-empty, else DUMMY; a push into an empty FIFO is visible the next cycle.
REQ-016 On iTake in RUN: if the FIFO is non-empty the head SHALL pop; if empty, oBubbles SHALL increment (saturating at 16'hFFFF) and no pop occurs.
REQ-017 When iTake and a push coincide on an empty FIFO, DUMMY SHALL be counted as taken and the pushed task SHALL be retained as the new head.
REQ-018 iTake in IDLE SHALL be ignored.
REQ-019 On iSolved, a result whose {iSolvedPlayer, iSolvedOpponent} equals DUMMY or its swap {0, all-ones} SHALL be discarded silently.
REQ-020 Any other result SHALL push {iSolvedPlayer, iSolvedOpponent, iSolvedRes} into the result FIFO; oResValid SHALL rise the cycle after the iSolved edge.
REQ-021 If the result FIFO is full with no same-cycle pop, the result SHALL be dropped and oOverflow set until reset; full with a simultaneous pop SHALL accept.
REQ-022 The result FIFO SHALL be first-word-fall-through: oResValid = non-empty, outputs show the head, and it pops on oResValid & iResReady.
REQ-023 All FIFO pointers SHALL wrap modulo depth, with full/empty distinguished by an extra pointer bit.
REQ-024 Results SHALL leave in iSolved arrival order; no task-to-result ordering is implied.

Reset
REQ-025 On inRESET low the block SHALL asynchronously enter IDLE and drive oEnable=0, oTaskReady=1, oResValid=0, oOverflow=0 and oBubbles=0, with both FIFOs emptied.
REQ-026 In reset, oPlayer/oOpponent SHALL show DUMMY and oResPlayer/oResOpponent/oRes SHALL be 0.
REQ-027 A reset mid-operation SHALL discard queued tasks and results; the first edge after release SHALL behave as fresh IDLE.

Verification
REQ-028 Push task A (player 0x0000_0008_1000_0000, opponent 0x0000_0010_0800_0000) after reset -> oPlayer=A.player next cycle, oEnable=1 one edge later.
REQ-029 Push TASK_DEPTH tasks with no iTake -> oTaskReady=0; one iTake -> one pop, ready=1 next cycle, oPlayer shows task 2.
REQ-030 iTake on an empty FIFO 3 times in RUN -> oBubbles=3; iSolved with DUMMY or swapped DUMMY payload -> oResValid stays 0.
REQ-031 9 non-dummy iSolved pulses with iResReady=0 -> 8 stored, oOverflow=1; repeat with iResReady=1 on the 9th -> nothing dropped, oOverflow=0.
REQ-032 iSolved with res=-12 -> next cycle oResValid=1, oRes=-12 (8'hF4), payload echoed; assert inRESET mid-burst -> all outputs take reset values immediately, not on a clock edge.
